// File: rtl/cpu_decode_pkg.sv
// Shared opcode, condition and ALU-op constants plus the decoded control bundle
// for the ARMv8-subset instruction decoder.
package cpu_decode_pkg;

  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_BR    = 11'b11010110000;
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;

  localparam logic [4:0]  COND_LT  = 5'b01011;

  localparam logic [2:0]  ALU_PASSB = 3'b000;
  localparam logic [2:0]  ALU_ADD   = 3'b010;
  localparam logic [2:0]  ALU_SUB   = 3'b011;

  typedef struct packed {
    logic       reg2loc;
    logic       alu_src;
    logic       alu_src1;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_wri;
    logic       read_mem;
    logic       br_taken;
    logic       uncond_br;
    logic [2:0] alu_op;
    logic       en_flags;
    logic       write_rd;
    logic       br;
  } ctrl_t;

  // Unrecognised opcodes fall back to this, which behaves as a NOP.
  function automatic ctrl_t nop_ctrl();
    ctrl_t c;
    c          = '0;
    c.reg2loc  = 1'b1;
    c.write_rd = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/cpu_decode_if.sv
// Bundle between the datapath (master) and the decode/PC core (slave):
// fetched instruction, flags, PC load path, control outputs and immediates.
interface cpu_decode_if #(
  parameter int PC_W = 64
);
  logic            pc_en;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] pc;
  logic [31:0]     instruction;
  logic            zero;
  logic            flag_neg;
  logic            flag_ovf;

  logic            Reg2Loc;
  logic            ALUsrc;
  logic            ALUsrc1;
  logic            MemtoReg;
  logic            RegWrite;
  logic            MemWri;
  logic            Readmem;
  logic            BrTaken;
  logic            UncondBr;
  logic [2:0]      ALUOp;
  logic            enFlags;
  logic            WriteRd;
  logic            BR;

  logic [PC_W-1:0] DAddr9;
  logic [PC_W-1:0] CondAddr19;
  logic [PC_W-1:0] BrAddr26;
  logic [PC_W-1:0] Imm12;

  modport master (
    output pc_en, pc_next, instruction, zero, flag_neg, flag_ovf,
    input  pc, Reg2Loc, ALUsrc, ALUsrc1, MemtoReg, RegWrite, MemWri, Readmem,
           BrTaken, UncondBr, ALUOp, enFlags, WriteRd, BR,
           DAddr9, CondAddr19, BrAddr26, Imm12
  );

  modport slave (
    input  pc_en, pc_next, instruction, zero, flag_neg, flag_ovf,
    output pc, Reg2Loc, ALUsrc, ALUsrc1, MemtoReg, RegWrite, MemWri, Readmem,
           BrTaken, UncondBr, ALUOp, enFlags, WriteRd, BR,
           DAddr9, CondAddr19, BrAddr26, Imm12
  );
endinterface

// File: rtl/cpu_decode_imm_extend.sv
// Immediate extender: pulls the four immediate fields out of the instruction
// and widens them to PC_W bits, unshifted (word scaling happens downstream).
module imm_extend #(
  parameter int PC_W = 64
) (
  input  logic [25:0]     instr_lo,
  output logic [PC_W-1:0] daddr9,
  output logic [PC_W-1:0] cond_addr19,
  output logic [PC_W-1:0] br_addr26,
  output logic [PC_W-1:0] imm12
);

  assign daddr9      = {{(PC_W-9){instr_lo[20]}},  instr_lo[20:12]};
  assign cond_addr19 = {{(PC_W-19){instr_lo[23]}}, instr_lo[23:5]};
  assign br_addr26   = {{(PC_W-26){instr_lo[25]}}, instr_lo[25:0]};
  assign imm12       = {{(PC_W-12){1'b0}},         instr_lo[21:10]};

endmodule

// File: rtl/cpu_decode_core.sv
// Combinational instruction decoder and immediate extender plus the PC register.
// Define CPU_DECODE_BLT_NV_EN to make B.LT use signed less-than (N xor V).
module cpu_decode_core
  import cpu_decode_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] PC_RESET = '0
) (
  input logic       clk,
  input logic       reset,
  cpu_decode_if.slave bus
);

  logic [PC_W-1:0] pc_q;
  logic [31:0]     ins;
  logic            lt;
  ctrl_t           ctl;

  assign ins    = bus.instruction;
  assign bus.pc = pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc_q <= PC_RESET;
    else if (bus.pc_en)
      pc_q <= bus.pc_next;
  end

`ifdef CPU_DECODE_BLT_NV_EN
  assign lt = bus.flag_neg ^ bus.flag_ovf;
`else
  logic unused_flag_ovf;
  assign unused_flag_ovf = bus.flag_ovf;
  assign lt = bus.flag_neg;
`endif

  // Priority chain: the first matching opcode wins, the rest decode as NOP.
  always_comb begin
    ctl = nop_ctrl();
    if (ins[31:22] == OP_ADDI) begin
      ctl.alu_src   = 1'b1;
      ctl.alu_src1  = 1'b1;
      ctl.reg_write = 1'b1;
      ctl.alu_op    = ALU_ADD;
    end else if (ins[31:21] == OP_ADDS) begin
      ctl.reg_write = 1'b1;
      ctl.alu_op    = ALU_ADD;
      ctl.en_flags  = 1'b1;
    end else if (ins[31:21] == OP_SUBS) begin
      ctl.reg_write = 1'b1;
      ctl.alu_op    = ALU_SUB;
      ctl.en_flags  = 1'b1;
    end else if (ins[31:21] == OP_LDUR) begin
      ctl.alu_src    = 1'b1;
      ctl.mem_to_reg = 1'b1;
      ctl.reg_write  = 1'b1;
      ctl.read_mem   = 1'b1;
      ctl.alu_op     = ALU_ADD;
    end else if (ins[31:21] == OP_STUR) begin
      ctl.reg2loc = 1'b0;
      ctl.alu_src = 1'b1;
      ctl.mem_wri = 1'b1;
      ctl.alu_op  = ALU_ADD;
    end else if (ins[31:21] == OP_BR) begin
      ctl.reg2loc = 1'b0;
      ctl.br      = 1'b1;
    end else if (ins[31:26] == OP_B) begin
      ctl.br_taken  = 1'b1;
      ctl.uncond_br = 1'b1;
    end else if (ins[31:26] == OP_BL) begin
      ctl.br_taken  = 1'b1;
      ctl.uncond_br = 1'b1;
      ctl.reg_write = 1'b1;
      ctl.write_rd  = 1'b0;
    end else if (ins[31:24] == OP_CBZ) begin
      ctl.reg2loc  = 1'b0;
      ctl.alu_op   = ALU_PASSB;
      ctl.br_taken = bus.zero;
    end else if (ins[31:24] == OP_BCOND) begin
      ctl.br_taken = (ins[4:0] == COND_LT) && lt;
    end
  end

  assign bus.Reg2Loc  = ctl.reg2loc;
  assign bus.ALUsrc   = ctl.alu_src;
  assign bus.ALUsrc1  = ctl.alu_src1;
  assign bus.MemtoReg = ctl.mem_to_reg;
  assign bus.RegWrite = ctl.reg_write;
  assign bus.MemWri   = ctl.mem_wri;
  assign bus.Readmem  = ctl.read_mem;
  assign bus.BrTaken  = ctl.br_taken;
  assign bus.UncondBr = ctl.uncond_br;
  assign bus.ALUOp    = ctl.alu_op;
  assign bus.enFlags  = ctl.en_flags;
  assign bus.WriteRd  = ctl.write_rd;
  assign bus.BR       = ctl.br;

  imm_extend #(.PC_W(PC_W)) u_imm_extend (
    .instr_lo    (ins[25:0]),
    .daddr9      (bus.DAddr9),
    .cond_addr19 (bus.CondAddr19),
    .br_addr26   (bus.BrAddr26),
    .imm12       (bus.Imm12)
  );

endmodule

// File: tb/tb_cpu_decode_core.sv
// Self-checking bench for cpu_decode_core: directed PC/decode cases plus random
// instructions compared against a mnemonic-level reference decoder.
module tb_cpu_decode_core;

  typedef struct packed {
    logic       reg2loc, alusrc, alusrc1, memtoreg, regwrite, memwri, readmem;
    logic       brtaken, uncondbr;
    logic [2:0] aluop;
    logic       enflags, writerd, br;
    logic [63:0] daddr9, condaddr19, braddr26, imm12;
  } exp_t;

  logic clk;
  logic reset;
  int   compareCount;
  int   mismatchCount;

  cpu_decode_if #(.PC_W(64)) bus ();

  cpu_decode_core #(.PC_W(64), .PC_RESET(64'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] sext(input longint field, input int bits);
    longint v;
    v = field;
    if (v >= (longint'(1) << (bits - 1)))
      v = v - (longint'(1) << bits);
    return 64'(v);
  endfunction

  // Reference decoder: classify by opcode value, then fill the per-mnemonic table row.
  function automatic exp_t refDecode(input bit [31:0] ins, input bit z, input bit n, input bit v);
    exp_t e;
    bit   lt;
`ifdef CPU_DECODE_BLT_NV_EN
    lt = n ^ v;
`else
    lt = n;
`endif
    e = '0;
    e.reg2loc = 1; e.writerd = 1;
    if ((ins >> 22) == 32'h244) begin
      e.alusrc = 1; e.alusrc1 = 1; e.regwrite = 1; e.aluop = 2;
    end else if ((ins >> 21) == 32'h558) begin
      e.regwrite = 1; e.aluop = 2; e.enflags = 1;
    end else if ((ins >> 21) == 32'h758) begin
      e.regwrite = 1; e.aluop = 3; e.enflags = 1;
    end else if ((ins >> 21) == 32'h7C2) begin
      e.alusrc = 1; e.memtoreg = 1; e.regwrite = 1; e.readmem = 1; e.aluop = 2;
    end else if ((ins >> 21) == 32'h7C0) begin
      e.reg2loc = 0; e.alusrc = 1; e.memwri = 1; e.aluop = 2;
    end else if ((ins >> 21) == 32'h6B0) begin
      e.reg2loc = 0; e.br = 1;
    end else if ((ins >> 26) == 32'h05) begin
      e.brtaken = 1; e.uncondbr = 1;
    end else if ((ins >> 26) == 32'h25) begin
      e.brtaken = 1; e.uncondbr = 1; e.regwrite = 1; e.writerd = 0;
    end else if ((ins >> 24) == 32'hB4) begin
      e.reg2loc = 0; e.brtaken = z;
    end else if ((ins >> 24) == 32'h54) begin
      e.brtaken = ((ins % 32) == 11) && lt;
    end
    e.daddr9     = sext(longint'((ins >> 12) % 512), 9);
    e.condaddr19 = sext(longint'((ins >> 5) % (1 << 19)), 19);
    e.braddr26   = sext(longint'(ins % (1 << 26)), 26);
    e.imm12      = 64'((ins >> 10) % 4096);
    return e;
  endfunction

  task automatic applyStimulus(input logic [31:0] ins, input logic z, input logic n, input logic v);
    bus.instruction = ins;
    bus.zero        = z;
    bus.flag_neg    = n;
    bus.flag_ovf    = v;
    #1;
  endtask

  task automatic checkAgainstModel(input string tag);
    exp_t e;
    e = refDecode(bus.instruction, bus.zero, bus.flag_neg, bus.flag_ovf);
    checkOutput({tag, ".Reg2Loc"},    64'(bus.Reg2Loc),  64'(e.reg2loc));
    checkOutput({tag, ".ALUsrc"},     64'(bus.ALUsrc),   64'(e.alusrc));
    checkOutput({tag, ".ALUsrc1"},    64'(bus.ALUsrc1),  64'(e.alusrc1));
    checkOutput({tag, ".MemtoReg"},   64'(bus.MemtoReg), 64'(e.memtoreg));
    checkOutput({tag, ".RegWrite"},   64'(bus.RegWrite), 64'(e.regwrite));
    checkOutput({tag, ".MemWri"},     64'(bus.MemWri),   64'(e.memwri));
    checkOutput({tag, ".Readmem"},    64'(bus.Readmem),  64'(e.readmem));
    checkOutput({tag, ".BrTaken"},    64'(bus.BrTaken),  64'(e.brtaken));
    checkOutput({tag, ".UncondBr"},   64'(bus.UncondBr), 64'(e.uncondbr));
    checkOutput({tag, ".ALUOp"},      64'(bus.ALUOp),    64'(e.aluop));
    checkOutput({tag, ".enFlags"},    64'(bus.enFlags),  64'(e.enflags));
    checkOutput({tag, ".WriteRd"},    64'(bus.WriteRd),  64'(e.writerd));
    checkOutput({tag, ".BR"},         64'(bus.BR),       64'(e.br));
    checkOutput({tag, ".DAddr9"},     bus.DAddr9,        e.daddr9);
    checkOutput({tag, ".CondAddr19"}, bus.CondAddr19,    e.condaddr19);
    checkOutput({tag, ".BrAddr26"},   bus.BrAddr26,      e.braddr26);
    checkOutput({tag, ".Imm12"},      bus.Imm12,         e.imm12);
  endtask

  initial begin
    logic [63:0] pcModel;
    logic [31:0] opBits [10];
    int          opShift [10];
    compareCount  = 0;
    mismatchCount = 0;

    reset       = 1'b1;
    bus.pc_en   = 1'b0;
    bus.pc_next = '0;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);

    // PC register: reset, load, asynchronous reset mid-cycle, hold.
    @(negedge clk);
    checkOutput("pc_reset", bus.pc, 64'h0);
    reset = 1'b0;
    bus.pc_en = 1'b1; bus.pc_next = 64'h40;
    @(posedge clk); #1;
    checkOutput("pc_load_40", bus.pc, 64'h40);
    #2 reset = 1'b1;
    #1 checkOutput("pc_async_reset", bus.pc, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    bus.pc_next = 64'h4;
    @(posedge clk); #1;
    checkOutput("pc_load_4", bus.pc, 64'h4);
    bus.pc_en = 1'b0; bus.pc_next = 64'h8;
    @(posedge clk); #1;
    checkOutput("pc_hold", bus.pc, 64'h4);

    pcModel = 64'h4;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.pc_en   = 1'($urandom_range(0, 1));
      bus.pc_next = {$urandom, $urandom};
      if (bus.pc_en) pcModel = bus.pc_next;
      @(posedge clk); #1;
      checkOutput("pc_random", bus.pc, pcModel);
    end

    // Directed decode cases.
    applyStimulus(32'h910017E0, 0, 0, 0);
    checkOutput("addi.ALUsrc", 64'(bus.ALUsrc), 1);
    checkOutput("addi.ALUsrc1", 64'(bus.ALUsrc1), 1);
    checkOutput("addi.RegWrite", 64'(bus.RegWrite), 1);
    checkOutput("addi.ALUOp", 64'(bus.ALUOp), 2);
    checkOutput("addi.Imm12", bus.Imm12, 64'd5);
    checkOutput("addi.enFlags", 64'(bus.enFlags), 0);

    applyStimulus((32'h7C2 << 21) | (32'h1F8 << 12) | 32'h41, 0, 0, 0);
    checkOutput("ldur.DAddr9", bus.DAddr9, 64'hFFFF_FFFF_FFFF_FFF8);
    checkOutput("ldur.MemtoReg", 64'(bus.MemtoReg), 1);
    checkOutput("ldur.Readmem", 64'(bus.Readmem), 1);
    applyStimulus((32'h7C0 << 21) | (32'h1F8 << 12) | 32'h41, 0, 0, 0);
    checkOutput("stur.MemWri", 64'(bus.MemWri), 1);
    checkOutput("stur.RegWrite", 64'(bus.RegWrite), 0);
    checkOutput("stur.Reg2Loc", 64'(bus.Reg2Loc), 0);
    checkOutput("stur.DAddr9", bus.DAddr9, 64'hFFFF_FFFF_FFFF_FFF8);

    applyStimulus((32'hB4 << 24) | (32'h7FFFF << 5) | 32'h3, 1, 0, 0);
    checkOutput("cbz_z1.BrTaken", 64'(bus.BrTaken), 1);
    checkOutput("cbz_z1.UncondBr", 64'(bus.UncondBr), 0);
    checkOutput("cbz_z1.CondAddr19", bus.CondAddr19, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus((32'hB4 << 24) | (32'h7FFFF << 5) | 32'h3, 0, 0, 0);
    checkOutput("cbz_z0.BrTaken", 64'(bus.BrTaken), 0);

    applyStimulus((32'h54 << 24) | 32'hB, 0, 1, 0);
    checkOutput("blt_n1v0.BrTaken", 64'(bus.BrTaken), 1);
    applyStimulus((32'h54 << 24) | 32'hB, 0, 1, 1);
`ifdef CPU_DECODE_BLT_NV_EN
    checkOutput("blt_n1v1.BrTaken", 64'(bus.BrTaken), 0);
`else
    checkOutput("blt_n1v1.BrTaken", 64'(bus.BrTaken), 1);
`endif
    applyStimulus((32'h54 << 24), 1, 1, 0);
    checkOutput("bcond_eq.BrTaken", 64'(bus.BrTaken), 0);

    applyStimulus((32'h25 << 26) | 32'h3FFFFFF, 0, 0, 0);
    checkOutput("bl.BrTaken", 64'(bus.BrTaken), 1);
    checkOutput("bl.UncondBr", 64'(bus.UncondBr), 1);
    checkOutput("bl.RegWrite", 64'(bus.RegWrite), 1);
    checkOutput("bl.WriteRd", 64'(bus.WriteRd), 0);
    checkOutput("bl.BrAddr26", bus.BrAddr26, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus((32'h6B0 << 21) | (32'd30 << 5), 0, 0, 0);
    checkOutput("br.BR", 64'(bus.BR), 1);
    checkOutput("br.RegWrite", 64'(bus.RegWrite), 0);
    applyStimulus(32'h0, 1, 1, 1);
    checkOutput("nop.RegWrite", 64'(bus.RegWrite), 0);
    checkOutput("nop.MemWri", 64'(bus.MemWri), 0);
    checkOutput("nop.BrTaken", 64'(bus.BrTaken), 0);
    checkOutput("nop.enFlags", 64'(bus.enFlags), 0);
    checkOutput("nop.Reg2Loc", 64'(bus.Reg2Loc), 1);
    checkOutput("nop.WriteRd", 64'(bus.WriteRd), 1);

    // Random instructions, mostly biased onto real opcodes.
    opBits  = '{32'h244, 32'h558, 32'h758, 32'h7C2, 32'h7C0, 32'h6B0, 32'h05, 32'h25, 32'hB4, 32'h54};
    opShift = '{22, 21, 21, 21, 21, 21, 26, 26, 24, 24};
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ins;
      int          k;
      ins = $urandom;
      k   = $urandom_range(0, 11);
      if (k < 10) begin
        ins = (ins & ((32'h1 << opShift[k]) - 1)) | (opBits[k] << opShift[k]);
        if (k == 9 && $urandom_range(0, 1) == 1)
          ins = (ins & ~32'h1F) | 32'hB;
      end
      applyStimulus(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checkAgainstModel($sformatf("rand%0d_%08h", i, ins));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/cpu_decode_core.md
Name: cpu_decode_core

Overview:
- Combinational instruction decoder and immediate extender for the single-cycle 64-bit ARMv8-subset CPU, plus the 64-bit program-counter register.
- Consumes the fetched 32-bit instruction and the ALU zero / stored flags.
- Drives every datapath select, write-enable and the ALU op, plus four 64-bit extended immediates.
- Holds the PC, which loads the next-PC value chosen by the datapath.

Parameters:
- PC_W, 64, width of PC and immediates
- PC_RESET, 64'h0, PC value after reset

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- pc_en  in  1  PC load enable (CPU ties to 1)
- pc_next  in  64  next PC from branch logic / BR mux
- pc  out  64  current PC
- instruction  in  32  fetched instruction
- zero  in  1  current-cycle ALU zero (CBZ)
- flag_neg  in  1  stored negative flag
- flag_ovf  in  1  stored overflow flag (used only with feature)
- Reg2Loc  out  1  1=read Rm[20:16], 0=read Rd[4:0]
- ALUsrc  out  1  1=ALU B is immediate, 0=register
- ALUsrc1  out  1  immediate select: 1=Imm12, 0=DAddr9
- MemtoReg  out  1  1=writeback from memory
- RegWrite  out  1  register-file write enable
- MemWri  out  1  data-memory write
- Readmem  out  1  data-memory read
- BrTaken  out  1  take PC-relative branch
- UncondBr  out  1  1=BrAddr26, 0=CondAddr19
- ALUOp  out  3  000 pass B, 010 add, 011 sub
- enFlags  out  1  latch ALU flags
- WriteRd  out  1  0=write PC+4 into X30 (BL), 1=normal Rd/result
- BR  out  1  1=next PC from register (BR)
- DAddr9, CondAddr19, BrAddr26, Imm12  out  64 each  extended immediates

Behaviour:
- PC: 64-bit register.
  - reset=1 forces pc=PC_RESET immediately, independent of clk.
  - Otherwise on posedge clk with pc_en=1, pc<=pc_next; with pc_en=0 it holds.
- Decode and extension are purely combinational, with zero latency.
- Immediates:
  - DAddr9 = sext(instr[20:12])
  - CondAddr19 = sext(instr[23:5])
  - BrAddr26 = sext(instr[25:0])
  - Imm12 = zero-extended instr[21:10]
  - No shift is applied; the word shift is done downstream.
- Defaults, used for any unmatched opcode (which then behaves as a NOP): all outputs 0 except Reg2Loc=1 and WriteRd=1.
- Opcode match order (first match wins):
  - ADDI [31:22]=1001000100: ALUsrc=1, ALUsrc1=1, RegWrite=1, ALUOp=010.
  - ADDS [31:21]=10101011000: RegWrite=1, ALUOp=010, enFlags=1.
  - SUBS [31:21]=11101011000: RegWrite=1, ALUOp=011, enFlags=1.
  - LDUR [31:21]=11111000010: ALUsrc=1, MemtoReg=1, RegWrite=1, Readmem=1, ALUOp=010.
  - STUR [31:21]=11111000000: Reg2Loc=0, ALUsrc=1, MemWri=1, ALUOp=010.
  - BR [31:21]=11010110000: Reg2Loc=0, BR=1.
  - B [31:26]=000101: BrTaken=1, UncondBr=1.
  - BL [31:26]=100101: BrTaken=1, UncondBr=1, RegWrite=1, WriteRd=0.
  - CBZ [31:24]=10110100: Reg2Loc=0, ALUOp=000, BrTaken=zero.
  - B.cond [31:24]=01010100: BrTaken=lt when instr[4:0]=01011 (LT); all other conditions give BrTaken=0.
- lt = flag_neg (see Optional Feature).
- Branch outputs never assert write enables, except BL's RegWrite.
- Reset does not affect decode outputs.

Optional Feature:
- Macro CPU_DECODE_BLT_NV_EN.
- Defined: lt = flag_neg XOR flag_ovf (architectural signed less-than).
- Undefined: lt = flag_neg and flag_ovf is ignored.

Decomposition:
- Package cpu_decode_pkg holds:
  - opcode constants (OP_ADDI, OP_ADDS, OP_SUBS, OP_LDUR, OP_STUR, OP_BR, OP_B, OP_BL, OP_CBZ, OP_BCOND)
  - COND_LT = 5'b01011
  - ALU op constants (ALU_PASSB=000, ALU_ADD=010, ALU_SUB=011)
- One sub-module, imm_extend, produces the four immediates.

Test Plan:
- Reset: assert reset mid-cycle with pc=0x40 -> pc=0 immediately; release, pc_next=4, pc_en=1 -> pc=4 after one posedge; pc_en=0 -> pc holds.
- ADDI 0x910017E0 -> ALUsrc=1, ALUsrc1=1, RegWrite=1, ALUOp=010, Imm12=5, enFlags=0.
- LDUR with imm9=0x1F8 -> DAddr9=0xFFFFFFFFFFFFFFF8, MemtoReg=1, Readmem=1. STUR with the same imm9 -> MemWri=1, RegWrite=0, Reg2Loc=0.
- CBZ with imm19=-1:
  - zero=1 -> BrTaken=1, UncondBr=0, CondAddr19=all ones.
  - zero=0 -> BrTaken=0.
- B.LT:
  - flag_neg=1, flag_ovf=0 -> BrTaken=1.
  - flag_neg=1, flag_ovf=1 -> BrTaken=1 without the macro, 0 with it.
  - Cond 00000 -> BrTaken=0.
- BL with imm26=0x3FFFFFF -> BrTaken=1, UncondBr=1, RegWrite=1, WriteRd=0, BrAddr26=-1. BR -> BR=1, RegWrite=0. Opcode 0x00000000 -> all enables 0.
